// File: rtl/temp_conv_ctrl.sv
// Capacitor-charge temperature conversion controller: discharge, timed charge, result handshake.
// Define TEMP_CTRL_AVG_EN to average four samples per conversion (default: one sample).
module temp_conv_ctrl #(
    parameter int DISCH_CYCLES = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    input  logic       continuous,
    input  logic       analog_out,
    output logic       cap_reset,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       timeout
);

    localparam logic [7:0] DISCH_LAST = 8'(DISCH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_V  = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DISCH, CHARGE, DONE} state_t;

    state_t     state_q, state_d;
    logic       sync_p0, sync_out;
    logic [7:0] disch_cnt;
    logic [7:0] cnt;
    logic [7:0] result_q;
    logic       timeout_q;

    logic       conv_clr;
    logic       capture;
    logic       last_sample;
    logic [7:0] sample_val;
    logic       sample_to;

`ifdef TEMP_CTRL_AVG_EN
    logic [1:0] idx;
    logic [9:0] acc;
    logic [9:0] sum_next;

    function automatic logic [7:0] avg_trunc(input logic [9:0] sum);
        return sum[9:2];
    endfunction

    assign sum_next    = acc + {2'b00, sample_val};
    assign last_sample = (idx == 2'd3);
`else
    assign last_sample = 1'b1;
`endif

    // A comparator edge wins over a coincident timeout: the sample is then a real reading.
    assign capture    = (state_q == CHARGE) && (sync_out || (cnt == TIMEOUT_V));
    assign sample_val = sync_out ? cnt : TIMEOUT_V;
    assign sample_to  = ~sync_out;

    always_comb begin
        state_d      = state_q;
        cap_reset    = 1'b1;
        busy         = 1'b1;
        result_valid = 1'b0;
        conv_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = DISCH;
                    conv_clr = 1'b1;
                end
            end
            DISCH: begin
                if (disch_cnt == DISCH_LAST) state_d = CHARGE;
            end
            CHARGE: begin
                cap_reset = 1'b0;
                if (capture) state_d = last_sample ? DONE : DISCH;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    if (continuous) begin
                        state_d  = DISCH;
                        conv_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= IDLE;
            sync_p0   <= 1'b0;
            sync_out  <= 1'b0;
            disch_cnt <= '0;
            cnt       <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_p0  <= analog_out;
            sync_out <= sync_p0;

            if (state_q == DISCH && state_d == DISCH) disch_cnt <= disch_cnt + 8'd1;
            else                                      disch_cnt <= '0;

            // Counter saturates implicitly: reaching TIMEOUT forces a capture and leaves CHARGE.
            if (state_q != CHARGE) cnt <= '0;
            else if (!capture)     cnt <= cnt + 8'd1;

            if (conv_clr)                  timeout_q <= 1'b0;
            else if (capture && sample_to) timeout_q <= 1'b1;

            if (capture && last_sample) begin
`ifdef TEMP_CTRL_AVG_EN
                result_q <= avg_trunc(sum_next);
`else
                result_q <= sample_val;
`endif
            end
        end
    end

`ifdef TEMP_CTRL_AVG_EN
    always_ff @(posedge clk) begin
        if (RESET) begin
            idx <= '0;
            acc <= '0;
        end else if (conv_clr) begin
            idx <= '0;
            acc <= '0;
        end else if (capture) begin
            idx <= idx + 2'd1;
            acc <= sum_next;
        end
    end
`endif

    assign result  = result_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_temp_conv_ctrl.sv
// Directed bench for temp_conv_ctrl; works in both the single-sample and averaging builds.
module tb_temp_conv_ctrl;

    logic       clk = 1'b0;
    logic       RESET, start, continuous, analog_out, result_ready;
    logic       cap_reset, busy, result_valid, timeout;
    logic [7:0] result;

    int cmp_cnt = 0;
    int err_cnt = 0;

`ifdef TEMP_CTRL_AVG_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    temp_conv_ctrl #(.DISCH_CYCLES(8), .TIMEOUT(255)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .start        (start),
        .continuous   (continuous),
        .analog_out   (analog_out),
        .cap_reset    (cap_reset),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Called at a negedge. Waits for CHARGE, raises analog_out t cycles later, drops it after capture.
    task automatic do_sample(input int t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cap_reset == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        repeat (t) @(posedge clk);
        #1 analog_out = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cap_reset == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        analog_out = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (result_valid == 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_ready();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b1; continuous = 1'b0; analog_out = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || cap_reset !== 1'b1 || result_valid !== 1'b0 ||
            result !== 8'd0 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b cap=%b vld=%b res=%0d to=%b expected 0 1 0 0 0",
                     busy, cap_reset, result_valid, result, timeout);
        end
        RESET = 1'b0; start = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int n;
        bit ok;
        pulse_start();
        n = 1;
        for (int i = 0; i < 50 && cap_reset == 1'b1; i++) begin
            @(negedge clk);
            if (cap_reset == 1'b1) n++;
        end
        cmp_cnt++;
        if (n != 8) begin
            err_cnt++;
            $display("FAIL disch_len: got %0d cycles expected 8", n);
        end
        for (int s = 0; s < NS; s++) do_sample(40, ok);
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd42 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_result: ok=%b res=%0d to=%b expected 42 0", ok, result, timeout);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (result_valid !== 1'b1 || result !== 8'd42) begin
                err_cnt++;
                $display("FAIL single_hold: vld=%b res=%0d expected 1 42", result_valid, result);
            end
        end
        pulse_ready();
        cmp_cnt++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_accept: vld=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        analog_out = 1'b0;
        pulse_start();
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd255 || timeout !== 1'b1 || cap_reset !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout: ok=%b res=%0d to=%b cap=%b expected 255 1 1",
                     ok, result, timeout, cap_reset);
        end
        pulse_ready();
    endtask

    task automatic test_zero_sample();
        bit ok;
        analog_out = 1'b1;
        pulse_start();
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd0 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL zero_sample: ok=%b res=%0d to=%b expected 0 0", ok, result, timeout);
        end
        analog_out = 1'b0;
        pulse_ready();
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        pulse_start();
        for (int s = 0; s < NS; s++) do_sample(5, ok);
        wait_valid(ok);
        for (int i = 0; i < 20; i++) begin
            start = (i == 10);
            @(negedge clk);
            cmp_cnt++;
            if (result_valid !== 1'b1 || result !== 8'd7 || timeout !== 1'b0) begin
                err_cnt++;
                $display("FAIL backpressure: cyc=%0d vld=%b res=%0d to=%b expected 1 7 0",
                         i, result_valid, result, timeout);
            end
        end
        start = 1'b0;
        continuous = 1'b1;
        pulse_ready();
        continuous = 1'b0;
        cmp_cnt++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || cap_reset !== 1'b1) begin
            err_cnt++;
            $display("FAIL continuous_restart: vld=%b busy=%b cap=%b expected 0 1 1",
                     result_valid, busy, cap_reset);
        end
        n = 1;
        for (int i = 0; i < 50 && cap_reset == 1'b1; i++) begin
            @(negedge clk);
            if (cap_reset == 1'b1) n++;
        end
        cmp_cnt++;
        if (n != 8) begin
            err_cnt++;
            $display("FAIL continuous_disch: got %0d cycles expected 8", n);
        end
        for (int s = 0; s < NS; s++) do_sample(1, ok);
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd3 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL continuous_result: ok=%b res=%0d to=%b expected 3 0", ok, result, timeout);
        end
        pulse_ready();
    endtask

`ifdef TEMP_CTRL_AVG_EN
    task automatic test_avg();
        bit ok;
        int ts[4] = '{10, 20, 30, 41};
        pulse_start();
        for (int s = 0; s < 4; s++) do_sample(ts[s], ok);
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd27 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL avg_result: ok=%b res=%0d to=%b expected 27 0", ok, result, timeout);
        end
        pulse_ready();
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        pulse_start();
        for (int i = 0; i < 100 && cap_reset == 1'b1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        RESET = 1'b1; start = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || cap_reset !== 1'b1 || result_valid !== 1'b0 ||
            result !== 8'd0 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid: busy=%b cap=%b vld=%b res=%0d to=%b expected 0 1 0 0 0",
                     busy, cap_reset, result_valid, result, timeout);
        end
        RESET = 1'b0; start = 1'b0;
        pulse_start();
        for (int s = 0; s < NS; s++) do_sample(3, ok);
        wait_valid(ok);
        cmp_cnt++;
        if (!ok || result !== 8'd5 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_recover: ok=%b res=%0d to=%b expected 5 0", ok, result, timeout);
        end
        RESET = 1'b1; result_ready = 1'b1; continuous = 1'b1;
        @(negedge clk);
        RESET = 1'b0; result_ready = 1'b0; continuous = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 8'd0) begin
            err_cnt++;
            $display("FAIL reset_vs_handshake: busy=%b vld=%b res=%0d expected 0 0 0",
                     busy, result_valid, result);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_zero_sample();
        test_back_to_back();
`ifdef TEMP_CTRL_AVG_EN
        test_avg();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/temp_conv_ctrl.md
TEMP_CONV_CTRL -- requirements
Module: temp_conv_ctrl

Interface
REQ-001 Parameter DISCH_CYCLES, default 8: number of cycles cap_reset is held high before each charge phase (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 255: count value at which a charge phase is aborted (legal range 1..255).
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high block reset.
REQ-005 Port start  input  1  one-cycle conversion request; honoured only in IDLE.
REQ-006 Port continuous  input  1  when high, a new conversion starts automatically after each result is accepted.
REQ-007 Port analog_out  input  1  asynchronous comparator output from the analog core; high means the capacitor reached the threshold.
REQ-008 Port cap_reset  output  1  discharge control to the analog core; high means the capacitor is held discharged.
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port result  output  8  conversion result, valid while result_valid is high.
REQ-011 Port result_valid  output  1  result handshake valid.
REQ-012 Port result_ready  input  1  result handshake ready from the consumer.
REQ-013 Port timeout  output  1  qualifies result; high if any sample in the conversion timed out.

Function
REQ-014 analog_out SHALL pass through a 2-flop synchronizer (sync_out) before any use.
REQ-015 FSM states SHALL be IDLE, DISCH, CHARGE and DONE.
REQ-016 IDLE: cap_reset=1, busy=0; start=1 -> DISCH, clearing the sample index, accumulator and timeout flag.
REQ-017 DISCH: cap_reset=1 for exactly DISCH_CYCLES cycles, then CHARGE with the 8-bit counter cleared to 0.
REQ-018 CHARGE: cap_reset=0; the counter SHALL increment once per cycle while sync_out=0.
REQ-019 In CHARGE, the first cycle with sync_out=1 SHALL capture the counter value as the sample; the captured value equals T+2, where T is the number of CHARGE cycles before analog_out is first sampled high.
REQ-020 If the counter reaches TIMEOUT before sync_out=1, the sample SHALL be TIMEOUT and the timeout flag SHALL be set; the counter never wraps.
REQ-021 After a capture, the FSM SHALL go to DISCH if samples remain, otherwise to DONE.
REQ-022 DONE: cap_reset=1, result_valid=1, and result and timeout SHALL be held stable until result_valid and result_ready are high on the same edge.
REQ-023 On that handshake, the FSM SHALL go to IDLE, or to DISCH (new conversion, state cleared) if continuous=1; result_valid SHALL drop in the following cycle.
REQ-024 start SHALL be ignored outside IDLE; start and continuous are sampled only in IDLE and DONE respectively.
REQ-025 If sync_out=1 on the first CHARGE cycle, the sample SHALL be 0, with no timeout.

Reset
REQ-026 RESET=1 on any edge, including mid-conversion, SHALL force IDLE with cap_reset=1, busy=0, result=0, result_valid=0, timeout=0, counter=0, accumulator=0, and synchronizer flops=0.
REQ-027 RESET SHALL take priority over start and over the handshake on the same edge.

Configuration
REQ-028 Macro TEMP_CTRL_AVG_EN defined: each conversion SHALL take 4 samples, sum them into a 10-bit accumulator, and set result = sum[9:2] (truncated); timeout is the OR of all 4 sample timeouts.
REQ-029 Macro TEMP_CTRL_AVG_EN undefined: each conversion SHALL take 1 sample, result = captured sample, and no accumulator logic is present.

Verification
REQ-030 Reset with start=1 held -> next cycle IDLE, cap_reset=1, result_valid=0, busy=0.
REQ-031 Single sample (macro off): start pulse, analog_out rises 40 CHARGE cycles after cap_reset falls -> cap_reset high for 8 cycles, then result=42, timeout=0, result_valid held until result_ready.
REQ-032 Timeout: analog_out tied low -> result=255, timeout=1, cap_reset returns high after capture.
REQ-033 Averaging (macro on): samples of T=10, 20, 30, 41 -> captures 12, 22, 32, 43, sum 109 -> result=27.
REQ-034 Backpressure plus continuous: result_ready low for 20 cycles -> result stable, no new DISCH; ready high with continuous=1 -> DISCH on the next cycle.
REQ-035 RESET asserted mid-CHARGE -> IDLE next cycle, no result_valid, and a subsequent start yields a normal conversion.
